// File: rtl/target_box_detect.sv
// target_box_detect: per-frame bounding box and foreground count of a mask.
// Build macro BOX_OVERLAY_EN draws the published box onto data_o.
module target_box_detect #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          MIN_PIXELS = 64,
    parameter logic [15:0] BOX_COLOR  = 16'hF800
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        vsync_i,
    input  logic        hsync_i,
    input  logic        data_en_i,
    input  logic [15:0] bin_data_i,
    output logic        vsync_o,
    output logic        hsync_o,
    output logic        data_en_o,
    output logic [15:0] data_o,
    output logic [10:0] box_x_min,
    output logic [10:0] box_x_max,
    output logic [10:0] box_y_min,
    output logic [10:0] box_y_max,
    output logic [19:0] pix_cnt,
    output logic        box_valid,
    output logic        box_update
);

    localparam logic [10:0] LP_H   = 11'(H_ACTIVE);
    localparam logic [10:0] LP_V   = 11'(V_ACTIVE);
    localparam logic [19:0] LP_MIN = 20'(MIN_PIXELS);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACCUM     = 2'd1,
        PUBLISH   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_publish;

    logic        r_vs_d;
    logic        r_de_d;
    logic        w_vs_rise;
    logic        w_line_end;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_hit;

    logic        r_pend;
    logic [19:0] r_cnt;
    logic [10:0] r_xmin;
    logic [10:0] r_xmax;
    logic [10:0] r_ymin;
    logic [10:0] r_ymax;

    logic        w_use_hit;
    logic        w_take;
    logic        w_empty;
    logic [19:0] w_b_cnt;
    logic [10:0] w_b_xmin;
    logic [10:0] w_b_xmax;
    logic [10:0] w_b_ymin;
    logic [10:0] w_b_ymax;
    logic [19:0] w_n_cnt;
    logic [10:0] w_n_xmin;
    logic [10:0] w_n_xmax;
    logic [10:0] w_n_ymin;
    logic [10:0] w_n_ymax;

    logic [15:0] w_pix_out;

    // A vsync rise restarts the frame on this very pixel, so it is column/row 0
    assign w_vs_rise  = vsync_i & ~r_vs_d;
    assign w_line_end = r_de_d & ~data_en_i;
    assign w_x        = w_vs_rise ? 11'd0 : r_x;
    assign w_y        = w_vs_rise ? 11'd0 : r_y;
    assign w_hit      = data_en_i & bin_data_i[0] & (w_x < LP_H) & (w_y < LP_V);

    // Edge detectors and pixel position counters (saturating, never wrap)
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
            r_x    <= 11'd0;
            r_y    <= 11'd0;
        end else begin
            r_vs_d <= vsync_i;
            r_de_d <= data_en_i;
            if (data_en_i) begin
                r_x <= (&w_x) ? w_x : w_x + 11'd1;
            end else if (w_vs_rise || w_line_end) begin
                r_x <= 11'd0;
            end
            if (w_vs_rise) begin
                r_y <= 11'd0;
            end else if (w_line_end && !(&r_y)) begin
                r_y <= r_y + 11'd1;
            end
        end
    end

    // Frame state register
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and selection of the accumulator base for this pixel
    always_comb begin
        w_next    = r_state;
        w_publish = 1'b0;
        w_use_hit = 1'b1;
        w_b_cnt   = r_cnt;
        w_b_xmin  = r_xmin;
        w_b_xmax  = r_xmax;
        w_b_ymin  = r_ymin;
        w_b_ymax  = r_ymax;
        unique case (r_state)
            WAIT_SYNC: begin
                w_b_cnt   = 20'd0;
                w_b_xmin  = 11'd0;
                w_b_xmax  = 11'd0;
                w_b_ymin  = 11'd0;
                w_b_ymax  = 11'd0;
                w_use_hit = w_vs_rise;
                if (w_vs_rise) w_next = ACCUM;
            end
            ACCUM: begin
                // Old frame is frozen; the rising-edge pixel waits in r_pend
                w_use_hit = ~w_vs_rise;
                if (w_vs_rise) w_next = PUBLISH;
            end
            PUBLISH: begin
                w_publish = 1'b1;
                w_next    = ACCUM;
                w_b_cnt   = {19'd0, r_pend};
                w_b_xmin  = 11'd0;
                w_b_xmax  = 11'd0;
                w_b_ymin  = 11'd0;
                w_b_ymax  = 11'd0;
            end
            default: w_next = WAIT_SYNC;
        endcase
    end

    // Fold the current pixel into the selected base
    always_comb begin
        w_take   = w_hit & w_use_hit;
        w_empty  = (w_b_cnt == 20'd0);
        w_n_cnt  = w_b_cnt;
        w_n_xmin = w_b_xmin;
        w_n_xmax = w_b_xmax;
        w_n_ymin = w_b_ymin;
        w_n_ymax = w_b_ymax;
        if (w_take) begin
            w_n_cnt  = (&w_b_cnt) ? w_b_cnt : w_b_cnt + 20'd1;
            w_n_xmin = (w_empty || w_x < w_b_xmin) ? w_x : w_b_xmin;
            w_n_xmax = (w_empty || w_x > w_b_xmax) ? w_x : w_b_xmax;
            w_n_ymin = (w_empty || w_y < w_b_ymin) ? w_y : w_b_ymin;
            w_n_ymax = (w_empty || w_y > w_b_ymax) ? w_y : w_b_ymax;
        end
    end

    // Frame accumulators
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_pend <= 1'b0;
            r_cnt  <= 20'd0;
            r_xmin <= 11'd0;
            r_xmax <= 11'd0;
            r_ymin <= 11'd0;
            r_ymax <= 11'd0;
        end else begin
            r_pend <= (r_state == ACCUM) & w_vs_rise & w_hit;
            r_cnt  <= w_n_cnt;
            r_xmin <= w_n_xmin;
            r_xmax <= w_n_xmax;
            r_ymin <= w_n_ymin;
            r_ymax <= w_n_ymax;
        end
    end

    // Published box, count and update pulse
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            box_x_min  <= 11'd0;
            box_x_max  <= 11'd0;
            box_y_min  <= 11'd0;
            box_y_max  <= 11'd0;
            pix_cnt    <= 20'd0;
            box_valid  <= 1'b0;
            box_update <= 1'b0;
        end else begin
            box_update <= w_publish;
            if (w_publish) begin
                pix_cnt <= r_cnt;
                if (r_cnt == 20'd0) begin
                    box_x_min <= 11'd0;
                    box_x_max <= 11'd0;
                    box_y_min <= 11'd0;
                    box_y_max <= 11'd0;
                    box_valid <= 1'b0;
                end else begin
                    box_x_min <= r_xmin;
                    box_x_max <= r_xmax;
                    box_y_min <= r_ymin;
                    box_y_max <= r_ymax;
                    box_valid <= (r_cnt >= LP_MIN);
                end
            end
        end
    end

`ifdef BOX_OVERLAY_EN
    logic w_in_x;
    logic w_in_y;
    logic w_on_col;
    logic w_on_row;
    logic w_edge;

    assign w_in_x    = (w_x >= box_x_min) && (w_x <= box_x_max);
    assign w_in_y    = (w_y >= box_y_min) && (w_y <= box_y_max);
    assign w_on_col  = ((w_x == box_x_min) || (w_x == box_x_max)) && w_in_y;
    assign w_on_row  = ((w_y == box_y_min) || (w_y == box_y_max)) && w_in_x;
    assign w_edge    = box_valid & data_en_i & (w_on_col | w_on_row);
    assign w_pix_out = w_edge ? BOX_COLOR : bin_data_i;
`else
    logic [15:0] w_unused_color;

    assign w_unused_color = BOX_COLOR;
    assign w_pix_out      = bin_data_i;
`endif

    // Video path, one register stage
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vsync_o   <= 1'b0;
            hsync_o   <= 1'b0;
            data_en_o <= 1'b0;
            data_o    <= 16'd0;
        end else begin
            vsync_o   <= vsync_i;
            hsync_o   <= hsync_i;
            data_en_o <= data_en_i;
            data_o    <= w_pix_out;
        end
    end

endmodule

// File: doc/target_box_detect.md
# target_box_detect

Frame-level bounding-box extractor for the binary mask stream produced by the 3x3 morphology stage. It consumes the RGB565-framed binary pixels (16'hFFFF foreground, 16'h0000 background) with their vsync/hsync/data_en timing and tracks the min/max column and row of foreground pixels per frame. At each frame boundary it publishes the box and the foreground pixel count to the colour-recognition control logic. It forwards the video stream one cycle late, optionally with the last box drawn on it.

## Interface
- H_ACTIVE, 640, active pixels per line; pixels with column >= H_ACTIVE are ignored for statistics.
- V_ACTIVE, 480, active lines per frame; lines with row >= V_ACTIVE are ignored for statistics.
- MIN_PIXELS, 64, minimum foreground count for a box to be reported valid.
- BOX_COLOR, 16'hF800, overlay colour (used only with the overlay feature compiled in).

Ports:
- sclk  in  1  pixel clock
- s_rst_n  in  1  reset, asynchronous, active-low
- vsync_i  in  1  frame sync; rising edge marks frame boundary
- hsync_i  in  1  line sync, passed through
- data_en_i  in  1  active-pixel strobe
- bin_data_i  in  16  binary pixel; bit 0 = 1 means foreground
- vsync_o / hsync_o / data_en_o  out  1  syncs and strobe delayed 1 cycle
- data_o  out  16  pixel out, 1-cycle delay
- box_x_min, box_x_max  out  11  published column bounds
- box_y_min, box_y_max  out  11  published row bounds
- pix_cnt  out  20  published foreground count, saturating at 20'hFFFFF
- box_valid  out  1  published box meets MIN_PIXELS
- box_update  out  1  one-cycle pulse when the published values change

## Operation
- Column counter x_cnt (11 bit):
  - cleared on vsync_i rise and at each line end;
  - otherwise +1 on every sampled data_en_i = 1;
  - first pixel of a line is column 0.
- Line end is data_en_i sampled 0 after a sampled 1. Row counter y_cnt (11 bit) +1 at each line end; cleared on vsync_i rise.
- A pixel is counted when all of these hold: data_en_i = 1, bin_data_i[0] = 1, x_cnt < H_ACTIVE, y_cnt < V_ACTIVE.
- For each counted pixel:
  - acc_cnt +1, saturating;
  - min/max accumulators updated with the current x_cnt/y_cnt;
  - the first counted pixel of a frame loads both min and max.
- FSM:
  - WAIT_SYNC (reset state): discard stats, go to ACCUM on the first vsync_i rise.
  - ACCUM: accumulate; on vsync_i rise go to PUBLISH.
  - PUBLISH (1 cycle): copy accumulators to the outputs, assert box_update, clear accumulators, return to ACCUM.
- A partial frame after reset is never published.
- In PUBLISH, box_valid = (acc_cnt >= MIN_PIXELS). If acc_cnt = 0, all box coordinate outputs are 0 and box_valid = 0; pix_cnt is still published.
- Pixels arriving during the PUBLISH cycle go to the new frame (clear and first update are merged).
- vsync_i rising while data_en_i = 1 is illegal upstream behaviour. The block still publishes and clears; that pixel starts the new frame at column 0.

## Timing
- Reset values: all outputs 0; FSM in WAIT_SYNC; counters and accumulators 0.
- Frame boundary: edge N is the first sclk edge sampling vsync_i = 1 after a sampled 0.
  - Published values and box_update = 1 appear at edge N+1.
  - box_update returns to 0 at edge N+2.
  - Published values hold until the next PUBLISH.
- Video path: vsync_o, hsync_o, data_en_o and data_o are registered copies of the inputs, exactly 1 cycle of latency, no gaps.
- Throughput: one pixel per clock, no backpressure.

## Configuration
- BOX_OVERLAY_EN defined:
  - data_o = BOX_COLOR when box_valid = 1, data_en_i = 1 and the pixel lies on the perimeter of the currently published box. Perimeter means (x_cnt == box_x_min or box_x_max, with y in range) or (y_cnt == box_y_min or box_y_max, with x in range).
  - Otherwise data_o = bin_data_i.
  - Latency is unchanged.
- Not defined: data_o = bin_data_i delayed 1 cycle, and no comparator logic is built.

## Test plan
- Reset, then 2 frames of 8x4 (H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=2) with foreground at (2,1),(5,3) -> no box_update at frame 1 start; at frame 2 start box_x 2..5, y 1..3, pix_cnt=2, box_valid=1, box_update high exactly 1 cycle.
- All-background frame -> coords 0, pix_cnt=0, box_valid=0, box_update pulses.
- Single foreground pixel at (7,0), MIN_PIXELS=1 -> min=max: x=7, y=0, box_valid=1. Same frame with MIN_PIXELS=2 -> box_valid=0, pix_cnt=1.
- Foreground at column 9 with H_ACTIVE=8 -> pixel ignored, pix_cnt excludes it.
- s_rst_n asserted mid-frame -> outputs 0 immediately; the following vsync rise produces no box_update, the next one publishes the full frame.
- BOX_OVERLAY_EN with published box 2..5 x 1..3 -> data_o = 16'hF800 at (2,1),(5,2),(3,3), and the input pixel value at (3,2); video latency 1 cycle in both builds.
